// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - in-order fetch-to-decode instruction buffer with show-ahead head output.
// Optional same-cycle empty-queue bypass is enabled by defining IQ_BYPASS_EN.
module instr_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [31:0]       instruction,
  input  logic [31:0]       now_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       out_instruction,
  output logic [31:0]       out_pc,
  output logic              out_compressed,
  output logic              iq_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] MARGIN   = (ADDR_W+1)'(FULL_MARGIN);

  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;

  logic enq_req;
  logic is_empty;
  logic is_full;
  logic bypass_take;
  logic do_deq;
  logic deq_mem;
  logic do_write;

  assign enq_req  = (instruction != 32'h0) && !flush;
  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);

`ifdef IQ_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = is_empty && enq_req;
  assign bypass_take = bypass_hit && out_ready;

  always_comb begin
    out_valid       = !is_empty || bypass_hit;
    out_instruction = mem[head][31:0];
    out_pc          = mem[head][63:32];
    if (bypass_hit) begin
      out_instruction = instruction;
      out_pc          = now_pc;
    end
  end
`else
  assign bypass_take     = 1'b0;
  assign out_valid       = !is_empty;
  assign out_instruction = mem[head][31:0];
  assign out_pc          = mem[head][63:32];
`endif

  assign out_compressed = (out_instruction[1:0] != 2'b11);
  assign iq_full        = ((FULL_CNT - count) <= MARGIN);

  // A bypassed word is handed straight to the consumer and never touches storage.
  assign do_deq   = out_valid && out_ready && !flush;
  assign deq_mem  = do_deq && !bypass_take;
  assign do_write = enq_req && !bypass_take && (!is_full || deq_mem);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[tail] <= {now_pc, instruction};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_write) begin
        tail <= tail + 1'b1;
      end
      if (deq_mem) begin
        head <= head + 1'b1;
      end
      if (do_write && !deq_mem) begin
        count <= count + 1'b1;
      end else if (deq_mem && !do_write) begin
        count <= count - 1'b1;
      end
      if (enq_req && is_full && !deq_mem) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed self-checking bench for instr_queue (either IQ_BYPASS_EN build).
module tb_instr_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] instruction;
  logic [31:0] now_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_compressed;
  logic        iq_full;
  logic [4:0]  count;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  instr_queue #(.DEPTH(16), .ADDR_W(4), .FULL_MARGIN(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .instruction     (instruction),
    .now_pc          (now_pc),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_compressed  (out_compressed),
    .iq_full         (iq_full),
    .count           (count),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
    instruction = ins;
    now_pc      = pc;
    out_ready   = rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (iq_full !== 1'b0) begin failures++; $display("FAIL reset_iq_full: got %b expected 0", iq_full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_in_order();
    drive(32'h00000013, 32'h0, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL order_valid: got %b expected 1", out_valid); end
    checks++; if (out_instruction !== 32'h13) begin failures++; $display("FAIL order_word0: got %h expected 00000013", out_instruction); end
    checks++; if (out_compressed !== 1'b0) begin failures++; $display("FAIL order_rvc0: got %b expected 0", out_compressed); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL order_count1: got %0d expected 1", count); end
    drive(32'h00004501, 32'h4, 1'b1);
    tick();
    checks++; if (out_instruction !== 32'h4501) begin failures++; $display("FAIL order_word1: got %h expected 00004501", out_instruction); end
    checks++; if (out_compressed !== 1'b1) begin failures++; $display("FAIL order_rvc1: got %b expected 1", out_compressed); end
    checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL order_pc1: got %h expected 00000004", out_pc); end
    drive(32'h0, 32'h0, 1'b1);
    tick();
    checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL order_drain: count %0d valid %b expected 0 0", count, out_valid); end
    drive(32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_full_margin();
    for (int i = 0; i < 14; i++) begin
      drive(32'h00100013 + i, 32'h1000 + 4 * i, 1'b0);
      tick();
      if (i == 12) begin
        checks++; if (iq_full !== 1'b0) begin failures++; $display("FAIL full_at13: got %b expected 0", iq_full); end
      end
    end
    checks++; if (count !== 5'd14) begin failures++; $display("FAIL full_count14: got %0d expected 14", count); end
    checks++; if (iq_full !== 1'b1) begin failures++; $display("FAIL full_at14: got %b expected 1", iq_full); end
    drive(32'h0, 32'h0, 1'b1);
    tick();
    checks++; if (count !== 5'd13) begin failures++; $display("FAIL full_deq_count: got %0d expected 13", count); end
    checks++; if (iq_full !== 1'b0) begin failures++; $display("FAIL full_deq_flag: got %b expected 0", iq_full); end
    checks++; if (out_pc !== 32'h1004) begin failures++; $display("FAIL full_deq_head: got %h expected 00001004", out_pc); end
  endtask

  task automatic test_overflow();
    for (int i = 14; i < 17; i++) begin
      drive(32'h00100013 + i, 32'h1000 + 4 * i, 1'b0);
      tick();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count16: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    drive(32'h00100013 + 17, 32'h1044, 1'b1);
    @(negedge clk);
    checks++; if (out_pc !== 32'h1004) begin failures++; $display("FAIL ovf_head_pre: got %h expected 00001004", out_pc); end
    tick();
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_enqdeq_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_enqdeq_flag: got %b expected 0", overflow); end
    checks++; if (out_pc !== 32'h1008) begin failures++; $display("FAIL ovf_head_post: got %h expected 00001008", out_pc); end
    drive(32'h00100013 + 18, 32'h1048, 1'b0);
    tick();
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_drop_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_drop_flag: got %b expected 1", overflow); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) begin
      drive(32'h0, 32'h0, 1'b1);
      tick();
    end
    checks++; if (count !== 5'd7) begin failures++; $display("FAIL flush_pre_count: got %0d expected 7", count); end
    checks++; if (out_pc !== 32'h102C) begin failures++; $display("FAIL flush_pre_head: got %h expected 0000102c", out_pc); end
    flush = 1'b1;
    drive(32'h00000013, 32'h2000, 1'b1);
    tick();
    flush = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL flush_overflow: got %b expected 1", overflow); end
    drive(32'h00000093, 32'h3000, 1'b0);
    tick();
    checks++; if (out_pc !== 32'h3000) begin failures++; $display("FAIL flush_restart_pc: got %h expected 00003000", out_pc); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 5; i++) begin
      drive(32'h00000093, 32'h3000 + 4 * i, 1'b0);
      tick();
    end
    drive(32'h0, 32'h0, 1'b0);
    checks++; if (count !== 5'd5) begin failures++; $display("FAIL areset_pre_count: got %0d expected 5", count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL areset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL areset_overflow: got %b expected 0", overflow); end
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    drive(32'h00000013, 32'h0, 1'b0);
    tick();
    for (int i = 1; i <= 40; i++) begin
      if (i < 40) drive(32'h00000013, 32'(4 * i), 1'b1);
      else        drive(32'h0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        failures++;
        $display("FAIL wrap_pc%0d: valid %b pc %h expected 1 %h", i, out_valid, out_pc, exp_pc);
      end
      exp_pc = exp_pc + 32'h4;
      tick();
    end
    drive(32'h0, 32'h0, 1'b0);
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL wrap_end_count: got %0d expected 0", count); end
  endtask

  task automatic test_bypass();
    drive(32'hABCD0013, 32'h100, 1'b1);
    @(negedge clk);
`ifdef IQ_BYPASS_EN
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid: got %b expected 1", out_valid); end
    checks++; if (out_pc !== 32'h100 || out_instruction !== 32'hABCD0013) begin failures++; $display("FAIL bypass_data: got %h/%h expected 00000100/abcd0013", out_pc, out_instruction); end
    tick();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL bypass_count: got %0d expected 0", count); end
`else
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nobypass_valid: got %b expected 0", out_valid); end
    tick();
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL nobypass_count: got %0d expected 1", count); end
    checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL nobypass_pc: got %h expected 00000100", out_pc); end
`endif
    drive(32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_margin();
    test_overflow();
    test_flush();
    test_async_reset();
    test_wrap();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
